// File: rtl/multiway_fifo_if.sv
// multiway_fifo_if
//   Bundles the write and read lane groups of a multi-lane FIFO.
//   The producer and consumer side use modport master.
//   The FIFO uses modport slave.
//   Signals:
//     wr_valid/wr_addr/wr_data  per-lane write request and payload.
//     wr_ready                  per-lane write accept.
//     rd_valid/rd_addr/rd_data  per-lane show-ahead head entries.
//     rd_ready                  per-lane consume.
interface multiway_fifo_if #(
  parameter int NUM_WAY = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
);
  logic [NUM_WAY-1:0]             wr_valid;
  logic [NUM_WAY-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_WAY-1:0][DATA_W-1:0] wr_data;
  logic [NUM_WAY-1:0]             wr_ready;
  logic [NUM_WAY-1:0]             rd_valid;
  logic [NUM_WAY-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_WAY-1:0][DATA_W-1:0] rd_data;
  logic [NUM_WAY-1:0]             rd_ready;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_addr, rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_addr, rd_data
  );
endinterface

// File: rtl/multiway_fifo.sv
// multiway_fifo
//   N-lane-in / N-lane-out FIFO of {addr, data} pairs.
//   Valid write lanes are compacted in lane order.
//   Reads are show-ahead: lane i presents entry head+i.
//   Ports:
//     clk, rst_n        clock; synchronous active-low reset.
//     flush             clears contents; error flags are kept.
//     bus (slave)       write and read lane groups; see multiway_fifo_if.
//     count             occupied entries (registered).
//     full, empty       count == DEPTH / count == 0.
//     almost_full       free entries <= AFULL_TH.
//     almost_empty      count <= AEMPTY_TH.
//     err_ovf           sticky: a valid write lane was refused outside flush.
//     err_rdu           sticky: rd_ready on a lane without rd_valid.
module multiway_fifo #(
  parameter int DEPTH     = 32,
  parameter int NUM_WAY   = 3,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int AFULL_TH  = 4,
  parameter int AEMPTY_TH = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  multiway_fifo_if.slave   bus,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             err_ovf,
  output logic             err_rdu
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_W + DATA_W;

  logic [EW-1:0]      mem [DEPTH];
  logic [PW-1:0]      head_reg, tail_reg;
  logic [CW-1:0]      count_reg;
  logic               err_ovf_reg, err_rdu_reg;

  logic [CW-1:0]      free;
  logic [CW-1:0]      k [NUM_WAY];
  logic [PW-1:0]      wr_idx [NUM_WAY];
  logic [PW-1:0]      rd_idx [NUM_WAY];
  logic [NUM_WAY-1:0] wr_ready_w;
  logic [NUM_WAY-1:0] rd_valid_w;
  logic [CW-1:0]      nw, nr;

  // Free slots come from the start-of-cycle count only.
  // Same-cycle pops never make room for writes, so rd_ready has no path to wr_ready.
  assign free = CW'(DEPTH) - count_reg;

  // k[i] is the rank of lane i among the valid lanes.
  // Lane i is accepted while its rank fits into the free slots, so accepted lanes form a prefix.
  // The pop count is the leading run of rd_ready & rd_valid.
  always_comb begin
    logic [CW-1:0] acc;
    logic          run;
    acc        = '0;
    run        = 1'b1;
    nw         = '0;
    nr         = '0;
    wr_ready_w = '0;
    k          = '{default: '0};
    for (int i = 0; i < NUM_WAY; i++) begin
      acc           = acc + CW'(bus.wr_valid[i]);
      k[i]          = acc;
      wr_ready_w[i] = bus.wr_valid[i] & (acc <= free) & ~flush;
      nw            = nw + CW'(wr_ready_w[i]);
      run           = run & bus.rd_ready[i] & rd_valid_w[i];
      nr            = nr + CW'(run);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_WAY; gi++) begin : g_lane
      assign wr_idx[gi]          = tail_reg + PW'(k[gi] - CW'(1));
      assign rd_idx[gi]          = head_reg + PW'(gi);
      assign rd_valid_w[gi]      = CW'(gi) < count_reg;
      assign bus.rd_valid[gi]    = rd_valid_w[gi];
      assign bus.wr_ready[gi]    = wr_ready_w[gi];
      assign {bus.rd_addr[gi], bus.rd_data[gi]} = rd_valid_w[gi] ? mem[rd_idx[gi]] : '0;
    end
  endgenerate

  // Storage contents are not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WAY; i++) begin
      if (wr_ready_w[i]) begin
        mem[wr_idx[i]] <= {bus.wr_addr[i], bus.wr_data[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      err_ovf_reg <= 1'b0;
      err_rdu_reg <= 1'b0;
    end else begin
      if (flush) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        head_reg  <= head_reg + PW'(nr);
        tail_reg  <= tail_reg + PW'(nw);
        count_reg <= count_reg + nw - nr;
      end
      if (!flush && |(bus.wr_valid & ~wr_ready_w)) begin
        err_ovf_reg <= 1'b1;
      end
      if (|(bus.rd_ready & ~rd_valid_w)) begin
        err_rdu_reg <= 1'b1;
      end
    end
  end

  assign count        = count_reg;
  assign full         = count_reg == CW'(DEPTH);
  assign empty        = count_reg == '0;
  assign almost_full  = free <= CW'(AFULL_TH);
  assign almost_empty = count_reg <= CW'(AEMPTY_TH);
  assign err_ovf      = err_ovf_reg;
  assign err_rdu      = err_rdu_reg;
endmodule

// File: tb/tb_multiway_fifo.sv
// tb_multiway_fifo
//   Directed and scoreboarded checks of multiway_fifo with DEPTH=8, NUM_WAY=3 and 16-bit fields.
//   Each written entry carries data equal to ~addr.
module tb_multiway_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, err_ovf, err_rdu;
  int         n_cmp = 0;
  int         n_bad = 0;

  multiway_fifo_if #(.NUM_WAY(3), .ADDR_W(16), .DATA_W(16)) bus ();

  multiway_fifo #(
    .DEPTH(8), .NUM_WAY(3), .ADDR_W(16), .DATA_W(16), .AFULL_TH(4), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .err_ovf(err_ovf), .err_rdu(err_rdu)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] wv, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input logic [2:0] rr);
    bus.wr_valid   = wv;
    bus.wr_addr[0] = a0;
    bus.wr_addr[1] = a1;
    bus.wr_addr[2] = a2;
    bus.wr_data[0] = ~a0;
    bus.wr_data[1] = ~a1;
    bus.wr_data[2] = ~a2;
    bus.rd_ready   = rr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      n_bad++; $display("FAIL reset_flags got %b want 1100", {empty, almost_empty, full, almost_full}); end
    n_cmp++; if (bus.rd_valid !== 3'b000) begin n_bad++; $display("FAIL reset_rd_valid got %b want 000", bus.rd_valid); end
    n_cmp++; if (bus.rd_addr !== 48'h0 || bus.rd_data !== 48'h0) begin
      n_bad++; $display("FAIL reset_rd_bus got %h/%h want 0/0", bus.rd_addr, bus.rd_data); end
    n_cmp++; if ({err_ovf, err_rdu} !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b want 00", {err_ovf, err_rdu}); end
  endtask

  task automatic test_fill_overflow();
    logic [2:0] exp_rdy [3] = '{3'b111, 3'b111, 3'b011};
    logic [2:0] rr_seq  [3] = '{3'b111, 3'b111, 3'b011};
    int         e;
    for (int c = 0; c < 3; c++) begin
      set_in(3'b111, 16'(3 * c), 16'(3 * c + 1), 16'(3 * c + 2), 3'b000);
      #1;
      n_cmp++; if (bus.wr_ready !== exp_rdy[c]) begin
        n_bad++; $display("FAIL fill_wr_ready cycle %0d got %b want %b", c, bus.wr_ready, exp_rdy[c]); end
      tick();
    end
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_count got %0d want 8", count); end
    n_cmp++; if ({full, almost_full, empty, err_ovf} !== 4'b1101) begin
      n_bad++; $display("FAIL fill_flags got %b want 1101", {full, almost_full, empty, err_ovf}); end
    e = 0;
    for (int c = 0; c < 3; c++) begin
      set_in(3'b000, 16'h0, 16'h0, 16'h0, rr_seq[c]);
      #1;
      for (int j = 0; j < 3; j++) begin
        if (rr_seq[c][j]) begin
          n_cmp++; if (bus.rd_addr[j] !== 16'(e) || bus.rd_data[j] !== ~16'(e)) begin
            n_bad++; $display("FAIL fill_drain lane %0d got %h/%h want %h", j, bus.rd_addr[j], bus.rd_data[j], 16'(e)); end
          e++;
        end
      end
      tick();
    end
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL fill_drain_end got count %0d empty %b want 0 1", count, empty); end
    do_reset();
  endtask

  task automatic test_compaction();
    set_in(3'b101, 16'hA0A0, 16'h1111, 16'hA2A2, 3'b000);
    #1;
    n_cmp++; if (bus.wr_ready !== 3'b101) begin n_bad++; $display("FAIL compact_wr_ready got %b want 101", bus.wr_ready); end
    tick();
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (bus.rd_valid !== 3'b011) begin n_bad++; $display("FAIL compact_rd_valid got %b want 011", bus.rd_valid); end
    n_cmp++; if (bus.rd_addr !== {16'h0, 16'hA2A2, 16'hA0A0}) begin
      n_bad++; $display("FAIL compact_rd_addr got %h want 0000a2a2a0a0", bus.rd_addr); end
    n_cmp++; if (bus.rd_data[1] !== ~16'hA2A2) begin n_bad++; $display("FAIL compact_rd_data got %h want %h", bus.rd_data[1], ~16'hA2A2); end
    n_cmp++; if (count !== 4'd2 || err_ovf !== 1'b0 || almost_empty !== 1'b1) begin
      n_bad++; $display("FAIL compact_status got count %0d ovf %b aempty %b want 2 0 1", count, err_ovf, almost_empty); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_l [6] = '{16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hC0C0, 16'hC1C1, 16'hD0D0};
    set_in(3'b111, 16'hB0B0, 16'hB1B1, 16'hB2B2, 3'b000);
    tick();
    set_in(3'b011, 16'hC0C0, 16'hC1C1, 16'h0, 3'b000);
    tick();
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL simul_pre_count got %0d want 7", count); end
    set_in(3'b111, 16'hD0D0, 16'hD1D1, 16'hD2D2, 3'b011);
    #1;
    n_cmp++; if (bus.wr_ready !== 3'b001) begin n_bad++; $display("FAIL simul_wr_ready got %b want 001", bus.wr_ready); end
    n_cmp++; if (bus.rd_addr[0] !== 16'hA0A0 || bus.rd_addr[1] !== 16'hA2A2) begin
      n_bad++; $display("FAIL simul_head got %h %h want a0a0 a2a2", bus.rd_addr[0], bus.rd_addr[1]); end
    tick();
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (count !== 4'd6 || almost_full !== 1'b1) begin
      n_bad++; $display("FAIL simul_count got %0d afull %b want 6 1", count, almost_full); end
    for (int c = 0; c < 2; c++) begin
      set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b111);
      #1;
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (bus.rd_addr[j] !== exp_l[3 * c + j] || bus.rd_data[j] !== ~exp_l[3 * c + j]) begin
          n_bad++; $display("FAIL simul_order lane %0d got %h want %h", j, bus.rd_addr[j], exp_l[3 * c + j]); end
      end
      tick();
    end
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL simul_end_count got %0d want 0", count); end
  endtask

  task automatic test_stream();
    logic [15:0] q [$];
    logic [15:0] a [3];
    logic [2:0]  wv, rr, exp_rdy;
    int          nrd, free, k, lim;
    for (int c = 0; c < 40; c++) begin
      wv  = 3'($urandom_range(0, 7));
      lim = (q.size() < 3) ? q.size() : 3;
      nrd = $urandom_range(0, lim);
      rr  = 3'b000;
      for (int j = 0; j < nrd; j++) rr[j] = 1'b1;
      for (int j = 0; j < 3; j++) a[j] = 16'($urandom);
      set_in(wv, a[0], a[1], a[2], rr);
      #1;
      free    = 8 - q.size();
      k       = 0;
      exp_rdy = 3'b000;
      for (int j = 0; j < 3; j++) begin
        if (wv[j]) begin
          k++;
          exp_rdy[j] = (k <= free);
        end
      end
      n_cmp++; if (bus.wr_ready !== exp_rdy) begin
        n_bad++; $display("FAIL stream_wr_ready cycle %0d got %b want %b", c, bus.wr_ready, exp_rdy); end
      for (int j = 0; j < nrd; j++) begin
        n_cmp++; if (bus.rd_addr[j] !== q[j] || bus.rd_data[j] !== ~q[j]) begin
          n_bad++; $display("FAIL stream_rd cycle %0d lane %0d got %h want %h", c, j, bus.rd_addr[j], q[j]); end
      end
      for (int j = 0; j < nrd; j++) void'(q.pop_front());
      for (int j = 0; j < 3; j++) if (exp_rdy[j]) q.push_back(a[j]);
      tick();
      n_cmp++; if (count !== 4'(q.size()) || count > 4'd8) begin
        n_bad++; $display("FAIL stream_count cycle %0d got %0d want %0d", c, count, q.size()); end
    end
    do_reset();
  endtask

  task automatic test_partial_pop();
    set_in(3'b111, 16'hE0E0, 16'hE1E1, 16'hE2E2, 3'b000);
    tick();
    set_in(3'b011, 16'hE3E3, 16'hE4E4, 16'h0, 3'b000);
    tick();
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL ppop_pre_count got %0d want 5", count); end
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b101);
    tick();
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (count !== 4'd4 || bus.rd_addr[0] !== 16'hE1E1 || err_rdu !== 1'b0) begin
      n_bad++; $display("FAIL ppop_result got count %0d head %h rdu %b want 4 e1e1 0", count, bus.rd_addr[0], err_rdu); end
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b111);
    tick();
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b001);
    tick();
    n_cmp++; if (count !== 4'd0 || err_rdu !== 1'b0) begin
      n_bad++; $display("FAIL ppop_drain got count %0d rdu %b want 0 0", count, err_rdu); end
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b100);
    tick();
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (err_rdu !== 1'b1) begin n_bad++; $display("FAIL underflow_err got %b want 1", err_rdu); end
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1 || bus.rd_valid !== 3'b000) begin
      n_bad++; $display("FAIL underflow_state got count %0d empty %b rdv %b want 0 1 000", count, empty, bus.rd_valid); end
  endtask

  task automatic test_flush_reset();
    set_in(3'b111, 16'h0101, 16'h0202, 16'h0303, 3'b000);
    tick();
    set_in(3'b111, 16'h0404, 16'h0505, 16'h0606, 3'b000);
    tick();
    n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL flush_pre_count got %0d want 6", count); end
    set_in(3'b111, 16'h0707, 16'h0808, 16'h0909, 3'b000);
    flush = 1'b1;
    #1;
    n_cmp++; if (bus.wr_ready !== 3'b000) begin n_bad++; $display("FAIL flush_wr_ready got %b want 000", bus.wr_ready); end
    tick();
    flush = 1'b0;
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1 || bus.rd_valid !== 3'b000) begin
      n_bad++; $display("FAIL flush_state got count %0d empty %b rdv %b want 0 1 000", count, empty, bus.rd_valid); end
    n_cmp++; if ({err_ovf, err_rdu} !== 2'b01) begin
      n_bad++; $display("FAIL flush_err got %b want 01", {err_ovf, err_rdu}); end
    set_in(3'b001, 16'hF0F0, 16'h0, 16'h0, 3'b000);
    tick();
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (count !== 4'd1 || bus.rd_addr[0] !== 16'hF0F0) begin
      n_bad++; $display("FAIL flush_after_write got count %0d head %h want 1 f0f0", count, bus.rd_addr[0]); end
    for (int c = 0; c < 3; c++) begin
      set_in(3'b111, 16'h1000 + 16'(c), 16'h2000 + 16'(c), 16'h3000 + 16'(c), 3'b000);
      tick();
    end
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    #1;
    n_cmp++; if (err_ovf !== 1'b1 || count !== 4'd8) begin
      n_bad++; $display("FAIL flush_ovf got ovf %b count %0d want 1 8", err_ovf, count); end
    do_reset();
    #1;
    n_cmp++; if ({err_ovf, err_rdu} !== 2'b00 || count !== 4'd0) begin
      n_bad++; $display("FAIL final_reset got err %b count %0d want 00 0", {err_ovf, err_rdu}, count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
    test_reset();
    test_fill_overflow();
    test_compaction();
    test_simultaneous();
    test_stream();
    test_partial_pop();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multiway_fifo.md
# multiway_fifo

Parametrised N-lane-in / N-lane-out FIFO buffering {addr, data} pairs extracted from image streams, placed between the pixel/address extraction front end and the downstream multi-issue consumers. Up to NUM_WAY entries are pushed and up to NUM_WAY entries are popped per cycle. Write lanes are compacted in lane order, and reads are show-ahead. The block provides occupancy count, programmable almost-full/almost-empty flags, flush, and sticky error reporting.

## Interface
- DEPTH, 32: number of entries; power of 2, must be at least 2*NUM_WAY.
- NUM_WAY, 3: lanes per side; 1..8.
- ADDR_W, 64: address field width.
- DATA_W, 64: data field width.
- AFULL_TH, 4: almost_full asserts when free entries <= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH.
- CW: localparam, clog2(DEPTH+1).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of contents; does not clear err_*.
- wr_valid  in  NUM_WAY  per-lane write request.
- wr_addr  in  NUM_WAY x ADDR_W  per-lane address.
- wr_data  in  NUM_WAY x DATA_W  per-lane data.
- wr_ready  out  NUM_WAY  per-lane accept (combinational).
- rd_valid  out  NUM_WAY  lane i holds entry head+i.
- rd_ready  in  NUM_WAY  per-lane consume.
- rd_addr  out  NUM_WAY x ADDR_W  show-ahead address, 0 when lane invalid.
- rd_data  out  NUM_WAY x DATA_W  show-ahead data, 0 when lane invalid.
- count  out  CW  occupied entries.
- full, empty, almost_full, almost_empty  out  1 each  status flags, derived from registered count.
- err_ovf  out  1  sticky; set when any wr_valid lane is refused.
- err_rdu  out  1  sticky; set when rd_ready is asserted on a lane with rd_valid=0.

## Operation
- State: storage array[DEPTH], head and tail (log2 DEPTH bits, natural wrap), and count register.
- free = DEPTH - count, taken from the start-of-cycle count. Same-cycle pops do not free write slots.
- Write compaction:
  - k_i = popcount(wr_valid[i:0]).
  - wr_ready[i] = wr_valid[i] & (k_i <= free).
  - Accepted lane i is written to array[tail + k_i - 1], so gaps in wr_valid are squeezed out and lane order is preserved.
  - nw = number of accepted lanes. tail advances by nw.
- Read:
  - rd_valid[i] = (i < count).
  - Pops are the leading run of ones in rd_ready & rd_valid. A non-thermometer rd_ready pops only that leading run; higher lanes are ignored.
  - nr = number of pops. head advances by nr.
- Simultaneous read and write are always legal: count_next = count + nw - nr. Storage regions never overlap because writes are limited to free slots.
- flush: head, tail and count are set to 0. Same-cycle writes and reads are discarded, and wr_ready is forced to 0 while flush=1.
- err_ovf is set if any lane has wr_valid=1 and wr_ready=0 while flush=0. err_rdu is set on any rd_ready lane with rd_valid=0. Both clear only on reset.
- Flags:
  - full = (count == DEPTH).
  - empty = (count == 0).
  - almost_full = (free <= AFULL_TH).
  - almost_empty = (count <= AEMPTY_TH).

## Timing
- Reset (rst_n=0 at an edge): head, tail and count go to 0. Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_addr and rd_data = 0, err_*=0. Storage contents are don't-care. Reset overrides flush and any traffic in the same cycle.
- wr_ready and rd_valid/rd_addr/rd_data are combinational from registered state and inputs. There is no combinational path from rd_ready to wr_ready.
- Write-to-read latency is 1 cycle: data accepted at edge t appears on rd_valid/rd_data after edge t.
- count and all flags update on the edge where the transfer occurs.
- Wrap-around: pointer arithmetic is modulo DEPTH. Lane i reads array[(head+i) mod DEPTH].
- Reset mid-burst: all in-flight accepts in that cycle are lost, and no error is flagged.

## Test plan
- Reset, then NUM_WAY=3, DEPTH=8: drive wr_valid=111 for 3 cycles with addr=0..7 -> acceptances 3, 3, 2. Third cycle wr_ready=011, err_ovf=1, full=1, count=8.
- Start empty, wr_valid=101 with addr A0, A2 -> next cycle rd_valid=011, rd_addr={A2, A0} (lanes 1, 0), count=2, err_ovf=0.
- count=7 (DEPTH=8), drive rd_ready=011 and wr_valid=111 in the same cycle -> only lane 0 accepted (free=1), 2 pops, count becomes 6, head order preserved.
- Stream 40 cycles of random 0..3 writes and thermometer reads -> scoreboard matches in order across at least 4 pointer wraps, and count never exceeds 8.
- count=5, rd_ready=101 -> only lane 0 popped, count=4. Then rd_ready=100 with count=0 -> err_rdu=1, no state change.
- count=6, assert flush together with wr_valid=111 -> count=0, empty=1, nothing written. Then assert rst_n=0 -> err_ovf and err_rdu clear.
